// File: rtl/vect_int_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM state type
// and default parameter values.
package vect_int_ctrl_pkg;

  localparam int          DEF_N_CH       = 8;
  localparam int          DEF_VEC_W      = 8;
  localparam int unsigned DEF_VEC_BASE   = 32'h0000_00F0;
  localparam int unsigned DEF_VEC_STRIDE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/vect_int_ctrl_prio.sv
// Lowest-index-first priority encoder: idx is the lowest set bit of req,
// valid is high when any bit is set.
module prio_enc_n #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan high to low so the lowest set bit is the last assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vect_int_ctrl.sv
// Vectored interrupt controller: edge/level capture, masking, nested
// priority arbitration against in-service channels, and a REQ/ack/GAP FSM.
module vect_int_ctrl
  import vect_int_ctrl_pkg::*;
#(
  parameter int               N_CH       = DEF_N_CH,
  parameter int               VEC_W      = DEF_VEC_W,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(DEF_VEC_BASE),
  parameter int unsigned      VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic [N_CH-1:0]  irq_in,
  input  logic             mask_we,
  input  logic [N_CH-1:0]  mask_in,
  input  logic             mode_we,
  input  logic [N_CH-1:0]  mode_in,
  input  logic             ien,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             int_req,
  output logic [VEC_W-1:0] vector,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  in_service,
  output logic [1:0]       fsm_state
);

  localparam int            IW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [N_CH-1:0] pending_q, in_service_q, prev_q, mask_q, mode_q;
  logic [N_CH-1:0] pending_d, in_service_d, below, cand, ack_oh, eoi_oh;
  logic [IW-1:0]   is_idx, cand_idx;
  logic            is_valid, cand_valid, latch, ack_take;
  logic [31:0]     vec_sum;

  prio_enc_n #(.N(N_CH), .W(IW)) u_is_enc (
    .req(in_service_q), .idx(is_idx), .valid(is_valid)
  );

  // A channel may only preempt when it outranks everything already in service.
  always_comb begin
    below = '0;
    for (int i = 0; i < N_CH; i++) begin
      below[i] = !is_valid || (i < int'(is_idx));
    end
  end

  assign cand = pending_q & ~mask_q & below;

  prio_enc_n #(.N(N_CH), .W(IW)) u_cand_enc (
    .req(cand), .idx(cand_idx), .valid(cand_valid)
  );

  // Handshake: int_req holds with a stable vector throughout REQ; a cycle with
  // int_ack high while int_req is high is the single accepting transfer.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    ack_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (ien && cand_valid) begin
          state_d = REQ;
          latch   = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d  = GAP;
          ack_take = 1'b1;
        end else if (!ien) begin
          state_d = IDLE;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // eoi clear happens before the ack set; a fresh edge beats the ack clear.
  assign ack_oh       = ack_take ? (ONE << idx_q) : '0;
  assign eoi_oh       = (eoi && is_valid) ? (ONE << is_idx) : '0;
  assign in_service_d = (in_service_q & ~eoi_oh) | ack_oh;
  assign pending_d    = (mode_q & ((pending_q & ~ack_oh) | (irq_in & ~prev_q)))
                      | (~mode_q & irq_in);

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      idx_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      prev_q       <= '0;
      mask_q       <= '1;
      mode_q       <= '1;
    end else begin
      if (latch)   idx_q  <= cand_idx;
      if (mask_we) mask_q <= mask_in;
      if (mode_we) mode_q <= mode_in;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      prev_q       <= irq_in;
    end
  end

  assign vec_sum    = 32'(VEC_BASE) + 32'(idx_q) * VEC_STRIDE;
  assign int_req    = (state_q == REQ);
  assign vector     = (state_q == REQ) ? vec_sum[VEC_W-1:0] : '0;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign fsm_state  = state_q;

endmodule
